// File: rtl/freq_calc.sv
// Measurement result consumer: converts {clk_cnt, sig_cnt} into a signal frequency
// in Hz with a 64-step restoring divider, one-entry pending buffer and valid/ready output.
module freq_calc #(
    parameter logic [31:0] CLK_FREQ = 32'd100_000_000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        meas_wr_en_i,
    input  logic [63:0] meas_wr_data_i,
    output logic        freq_valid_o,
    input  logic        freq_ready_i,
    output logic [31:0] freq_data_o,
    output logic [1:0]  freq_err_o,
    output logic        busy_o,
    output logic [15:0] drop_cnt_o
);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state;
    logic [5:0]  iter;
    logic        pend_vld;
    logic [63:0] pend_data;
    logic [63:0] num;
    logic [32:0] rem;
    logic [31:0] den;

    logic        hs;
    logic        load_opp;
    logic        load;
    logic [63:0] job;
    logic [96:0] step;

    // One restoring step: returns {remainder, numerator-with-quotient-bit}.
    function automatic logic [96:0] div_step(input logic [32:0] r,
                                             input logic [63:0] n,
                                             input logic [31:0] d);
        logic [32:0] r_sh;
        r_sh = {r[31:0], n[63]};
        if (r_sh >= {1'b0, d})
            div_step = {r_sh - {1'b0, d}, n[62:0], 1'b1};
        else
            div_step = {r_sh, n[62:0], 1'b0};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        hs       = (state == DONE) && freq_valid_o && freq_ready_i;
        load_opp = (state == IDLE) || hs;
        load     = load_opp && (pend_vld || meas_wr_en_i);
        job      = pend_vld ? pend_data : meas_wr_data_i;
        step     = div_step(rem, num, den);
    end

    assign busy_o = (state != IDLE);

    // Control and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            iter         <= '0;
            pend_vld     <= 1'b0;
            freq_valid_o <= 1'b0;
            freq_data_o  <= '0;
            freq_err_o   <= '0;
            drop_cnt_o   <= '0;
        end else begin
            // Pending buffer: a strobe is buffered unless it is loaded directly
            if (load_opp) begin
                if (pend_vld && !meas_wr_en_i)
                    pend_vld <= 1'b0;
            end else if (meas_wr_en_i) begin
                pend_vld <= 1'b1;
                if (pend_vld)
                    drop_cnt_o <= sat_inc16(drop_cnt_o);
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        state <= DIV;
                        iter  <= '0;
                    end
                end
                DIV: begin
                    if (den == '0) begin
                        state        <= DONE;
                        freq_valid_o <= 1'b1;
                        freq_data_o  <= '0;
                        freq_err_o   <= 2'b01;
                    end else begin
                        iter <= iter + 6'd1;
                        if (iter == 6'd63) begin
                            state        <= DONE;
                            freq_valid_o <= 1'b1;
                            if (step[63:32] != '0) begin
                                freq_data_o <= 32'hFFFF_FFFF;
                                freq_err_o  <= 2'b10;
                            end else begin
                                freq_data_o <= step[31:0];
                                freq_err_o  <= 2'b00;
                            end
                        end
                    end
                end
                DONE: begin
                    if (hs) begin
                        freq_valid_o <= 1'b0;
                        iter         <= '0;
                        state        <= load ? DIV : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Divider datapath and pending payload
    always_ff @(posedge clk_i) begin
        if (load) begin
            num <= 64'(job[31:0]) * 64'(CLK_FREQ);
            den <= job[63:32];
            rem <= '0;
        end else if (state == DIV) begin
            rem <= step[96:64];
            num <= step[63:0];
        end
        if (meas_wr_en_i && !(load_opp && !pend_vld))
            pend_data <= meas_wr_data_i;
    end

endmodule

// File: tb/tb_freq_calc.sv
// Directed bench for freq_calc: table of single jobs plus pending/drop, reset and
// drop-counter saturation sequences.
module tb_freq_calc;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        meas_wr_en_i = 1'b0;
    logic [63:0] meas_wr_data_i = '0;
    logic        freq_valid_o;
    logic        freq_ready_i = 1'b1;
    logic [31:0] freq_data_o;
    logic [1:0]  freq_err_o;
    logic        busy_o;
    logic [15:0] drop_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    freq_calc #(.CLK_FREQ(32'd100_000_000)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .meas_wr_en_i   (meas_wr_en_i),
        .meas_wr_data_i (meas_wr_data_i),
        .freq_valid_o   (freq_valid_o),
        .freq_ready_i   (freq_ready_i),
        .freq_data_o    (freq_data_o),
        .freq_err_o     (freq_err_o),
        .busy_o         (busy_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] clk_cnt;
        logic [31:0] sig_cnt;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] cc, input logic [31:0] sc);
        @(negedge clk_i);
        meas_wr_en_i   = 1'b1;
        meas_wr_data_i = {cc, sc};
        @(posedge clk_i);
        #1;
        meas_wr_en_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!freq_valid_o && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i);
            #1;
            if (freq_valid_o) seen++;
        end
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{32'd100_000_000, 32'd1000,      32'd1000,          2'b00, 64};
        vecs[1] = '{32'd3,           32'd1,         32'd33_333_333,    2'b00, 64};
        vecs[2] = '{32'd7,           32'd1_000_000, 32'hFFFF_FFFF,     2'b10, 64};
        vecs[3] = '{32'd0,           32'd5,         32'd0,             2'b01, 1};
        vecs[4] = '{32'd1,           32'd42,        32'd4_200_000_000, 2'b00, 64};
        vecs[5] = '{32'd1,           32'd43,        32'hFFFF_FFFF,     2'b10, 64};
        vecs[6] = '{32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'd100_000_000,   2'b00, 64};
        vecs[7] = '{32'd12345,       32'd0,         32'd0,             2'b00, 64};
        vecs[8] = '{32'd100,         32'd7,         32'd7_000_000,     2'b00, 64};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", 64'(freq_valid_o), 64'd0);
        check("rst_data",  64'(freq_data_o),  64'd0);
        check("rst_err",   64'(freq_err_o),   64'd0);
        check("rst_busy",  64'(busy_o),       64'd0);
        check("rst_drop",  64'(drop_cnt_o),   64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        freq_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].clk_cnt, vecs[i].sig_cnt);
            check($sformatf("v%0d_busy", i), 64'(busy_o), 64'd1);
            wait_valid(lat);
            check($sformatf("v%0d_lat", i),  64'(lat),         64'(vecs[i].exp_lat));
            check($sformatf("v%0d_data", i), 64'(freq_data_o), 64'(vecs[i].exp_data));
            check($sformatf("v%0d_err", i),  64'(freq_err_o),  64'(vecs[i].exp_err));
        end
        @(posedge clk_i);
        #1;
        check("tbl_end_valid", 64'(freq_valid_o), 64'd0);
        check("tbl_end_drop",  64'(drop_cnt_o),   64'd0);

        // A presented, B overwritten by C in pending, B never output
        freq_ready_i = 1'b0;
        send(32'd100, 32'd7);
        repeat (5) @(posedge clk_i);
        send(32'd3, 32'd1);
        repeat (5) @(posedge clk_i);
        send(32'd100_000_000, 32'd1000);
        check("abc_drop_early", 64'(drop_cnt_o), 64'd1);
        wait_valid(lat);
        check("abc_a_valid", 64'(freq_valid_o), 64'd1);
        check("abc_a_data",  64'(freq_data_o),  64'd7_000_000);
        check("abc_a_err",   64'(freq_err_o),   64'd0);
        repeat (4) @(posedge clk_i);
        #1;
        check("abc_hold_valid", 64'(freq_valid_o), 64'd1);
        check("abc_hold_data",  64'(freq_data_o),  64'd7_000_000);
        @(negedge clk_i);
        freq_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("abc_hs_valid", 64'(freq_valid_o), 64'd0);
        check("abc_hs_busy",  64'(busy_o),       64'd1);
        check("abc_hs_hold",  64'(freq_data_o),  64'd7_000_000);
        wait_valid(lat);
        check("abc_c_lat",  64'(lat),         64'd64);
        check("abc_c_data", 64'(freq_data_o), 64'd1000);
        check("abc_c_err",  64'(freq_err_o),  64'd0);
        count_valid(100, seen);
        check("abc_no_b", 64'(seen), 64'd0);
        check("abc_idle", 64'(busy_o), 64'd0);
        check("abc_drop", 64'(drop_cnt_o), 64'd1);

        // Reset mid-DIV with a pending entry
        send(32'd100, 32'd7);
        repeat (28) @(posedge clk_i);
        send(32'd3, 32'd1);
        rst_n_i = 1'b0;
        #1;
        check("mrst_valid", 64'(freq_valid_o), 64'd0);
        check("mrst_busy",  64'(busy_o),       64'd0);
        check("mrst_drop",  64'(drop_cnt_o),   64'd0);
        check("mrst_data",  64'(freq_data_o),  64'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        send(32'd100_000_000, 32'd1000);
        wait_valid(lat);
        check("mrst_lat",  64'(lat),         64'd64);
        check("mrst_res",  64'(freq_data_o), 64'd1000);
        count_valid(100, seen);
        check("mrst_no_pend", 64'(seen), 64'd0);

        // Drop counter saturation
        freq_ready_i = 1'b0;
        @(negedge clk_i);
        meas_wr_en_i   = 1'b1;
        meas_wr_data_i = {32'd1, 32'd1};
        repeat (65600) @(posedge clk_i);
        #1;
        meas_wr_en_i = 1'b0;
        check("sat_drop",  64'(drop_cnt_o),   64'hFFFF);
        check("sat_valid", 64'(freq_valid_o), 64'd1);
        check("sat_data",  64'(freq_data_o),  64'd100_000_000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
